// File: rtl/uart_pkg.sv
// Shared definitions for the block-assembling UART receiver.
// Parity modes, bit-FSM encoding and the parity helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_t;

  // Expected parity bit for a data byte in the given mode.
  function automatic logic par_bit(
    input logic [7:0] d,
    input int         mode
  );
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_block_rx_if.sv
// Byte stream from the bit receiver to the block assembler.
// busy is high whenever the bit FSM is outside IDLE.
interface uart_byte_if;

  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output data,
    output valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input data,
    input valid,
    input frame_err,
    input parity_err,
    input busy
  );

endinterface

// File: rtl/uart_rx_byte.sv
// Bit-level UART receiver: synchroniser, bit FSM, parity and stop checks.
// Emits one-cycle valid / frame_err / parity_err strobes.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 44,
  parameter int PARITY       = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx,
  uart_byte_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic      rx_s1;
  logic      rx_s2;
  logic      rx_d;
  logic      rx_fall;

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bad;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall  = rx_d & ~rx_s2;
  assign bus.busy = (state != IDLE);

  // Bit FSM; all strobes are registered and default low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      par_bad        <= 1'b0;
      bus.data       <= '0;
      bus.valid      <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.valid      <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_fall) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            idx     <= '0;
            par_bad <= 1'b0;
            state   <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_s2, shreg[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) begin
              state <= (PARITY != PAR_NONE) ? PAR : STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            par_bad <= (rx_s2 != par_bit(shreg, PARITY));
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s2) begin
              bus.frame_err <= 1'b1;
            end else if (par_bad) begin
              bus.parity_err <= 1'b1;
            end else begin
              bus.valid <= 1'b1;
              bus.data  <= shreg;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_block_rx.sv
// UART receiver assembling NBYTES-byte blocks with a valid/ready handoff.
// Adds slot storage, byte counting, overrun and idle timeout on top of uart_rx_byte.
module uart_block_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 44,
  parameter int NBYTES       = 16,
  parameter int PARITY       = 0,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  input  logic [$clog2(NBYTES)-1:0]  sel,
  output logic [7:0]                 byte_out,
  output logic [8*NBYTES-1:0]        block_out,
  output logic                       block_valid,
  input  logic                       block_ready,
  output logic [$clog2(NBYTES+1)-1:0] byte_cnt,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun,
  output logic                       timeout
);

  localparam int SW   = $clog2(NBYTES);
  localparam int CNTW = $clog2(NBYTES + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NBYTES - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NBYTES);

  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 2);
  localparam logic [TW-1:0] TO_LAST = TW'((TO_CYC > 0) ? TO_CYC - 1 : 0);
  localparam logic [TW-1:0] TO_SAT  = TW'(TO_CYC);

  logic          rst_s1;
  logic          rst_n;
  logic [7:0]    mem [NBYTES];
  logic [SW-1:0] wr_idx;
  logic [TW-1:0] to_cnt;
  logic          to_fire;
  logic          hs;

  uart_byte_if bus ();

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY       (PARITY)
  ) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus)
  );

  // Reset asserts immediately but releases two clocks later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_s1 <= 1'b0;
      rst_n  <= 1'b0;
    end else begin
      rst_s1 <= 1'b1;
      rst_n  <= rst_s1;
    end
  end

  assign frame_err  = bus.frame_err;
  assign parity_err = bus.parity_err;
  assign wr_idx     = byte_cnt[SW-1:0];
  assign hs         = block_valid & block_ready;

  assign to_fire = (TIMEOUT_BITS != 0) && !bus.busy &&
                   (to_cnt == TO_LAST) &&
                   (byte_cnt != '0) && (byte_cnt != FULL_CNT);

  // Idle-cycle counter; cleared whenever a frame is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (bus.busy) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_SAT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Slot storage, byte count, block handoff, overrun and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NBYTES; k++) begin
        mem[k] <= '0;
      end
      byte_cnt    <= '0;
      block_valid <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      if (hs) begin
        block_valid <= 1'b0;
        if (bus.valid) begin
          mem[0]   <= bus.data;
          byte_cnt <= CNTW'(1);
        end else begin
          byte_cnt <= '0;
        end
      end else if (bus.valid) begin
        if (block_valid) begin
          overrun <= 1'b1;
        end else begin
          mem[wr_idx] <= bus.data;
          byte_cnt    <= byte_cnt + CNTW'(1);
          if (byte_cnt == LAST_CNT) begin
            block_valid <= 1'b1;
          end
        end
      end else if (to_fire) begin
        timeout  <= 1'b1;
        byte_cnt <= '0;
      end
    end
  end

  // Slot 0 sits in the most significant byte.
  always_comb begin
    block_out = '0;
    for (int k = 0; k < NBYTES; k++) begin
      block_out[8*(NBYTES-k)-1 -: 8] = mem[k];
    end
  end

  // Random-access byte read; out-of-range selects read as zero.
  always_comb begin
    byte_out = 8'h00;
    if (int'(sel) < NBYTES) begin
      byte_out = mem[sel];
    end
  end

endmodule

// File: tb/tb_uart_block_rx.sv
// Self-checking bench for uart_block_rx with an event scoreboard.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_uart_block_rx;

  localparam int CPB = 4;
  localparam int NB  = 8;

  localparam int EV_BYTE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;
  localparam int EV_OVR  = 3;
  localparam int EV_TO   = 4;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic          clk;
  logic          rst;
  logic          rx;
  logic [2:0]    sel;
  logic [7:0]    byte_out;
  logic [63:0]   block_out;
  logic          block_valid;
  logic          block_ready;
  logic [3:0]    byte_cnt;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          timeout;

  int  n_checks = 0;
  int  n_errors = 0;
  ev_t sb[$];
  int  m_cnt   = 0;
  bit  m_valid = 0;
  int  prev_cnt = 0;

  logic [63:0] blk_exp;
  logic [7:0]  blk_bytes [NB];

  uart_block_rx #(
    .CLKS_PER_BIT (CPB),
    .NBYTES       (NB),
    .PARITY       (2),
    .TIMEOUT_BITS (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .sel         (sel),
    .byte_out    (byte_out),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .byte_cnt    (byte_cnt),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_ev", 64'(kind), 64'hFF);
    end else begin
      e = sb.pop_front();
      check("ev_kind", 64'(kind), 64'(e.kind));
      if (e.kind == EV_BYTE) begin
        check("ev_byte", 64'(val), 64'(e.val));
      end
    end
  endtask

  function automatic logic [7:0] slot_of(input int k);
    return block_out[8*(NB-k)-1 -: 8];
  endfunction

  task automatic send_byte(
    input logic [7:0] v,
    input bit         stop,
    input bit         flip
  );
    if (!stop) begin
      push(EV_FERR, 0);
    end else if (flip) begin
      push(EV_PERR, 0);
    end else if (m_valid) begin
      push(EV_OVR, 0);
    end else begin
      push(EV_BYTE, m_cnt * 256 + int'(v));
      m_cnt++;
      if (m_cnt == NB) m_valid = 1;
    end
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (CPB) tick();
    end
    rx = (^v) ^ flip;
    repeat (CPB) tick();
    rx = stop;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: every pulse and every slot write must match the queue.
  always @(negedge clk) begin
    if (!rst) begin
      prev_cnt = 0;
    end else begin
      if (frame_err)  expect_ev(EV_FERR, 0);
      if (parity_err) expect_ev(EV_PERR, 0);
      if (overrun)    expect_ev(EV_OVR, 0);
      if (timeout)    expect_ev(EV_TO, 0);
      if (int'(byte_cnt) == prev_cnt + 1) begin
        expect_ev(EV_BYTE, prev_cnt * 256 + int'(slot_of(prev_cnt)));
      end
      prev_cnt = int'(byte_cnt);
    end
  end

  initial begin
    rst         = 1'b0;
    rx          = 1'b1;
    sel         = 3'd0;
    block_ready = 1'b0;
    repeat (3) tick();
    check("rst_cnt", 64'(byte_cnt), 64'd0);
    check("rst_valid", 64'(block_valid), 64'd0);
    check("rst_block", block_out, 64'd0);
    check("rst_pulses", 64'({frame_err, parity_err, overrun, timeout}), 64'd0);
    check("rst_byte_out", 64'(byte_out), 64'd0);
    rst = 1'b1;
    repeat (6) tick();

    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (20) tick();
    check("glitch_cnt", 64'(byte_cnt), 64'd0);

    blk_bytes = '{8'h02, 8'h01, 8'h0F, 8'hAA, 8'h55, 8'h3C, 8'hC3, 8'h03};
    for (int i = 0; i < NB; i++) begin
      send_byte(blk_bytes[i], 1'b1, 1'b0);
    end
    wait_drain(200);
    blk_exp = 64'h02010FAA553CC303;
    check("blk_valid", 64'(block_valid), 64'd1);
    check("blk_cnt", 64'(byte_cnt), 64'd8);
    check("blk_out", block_out, blk_exp);
    sel = 3'd3;
    #1;
    check("byte_out_sel3", 64'(byte_out), 64'hAA);
    sel = 3'd7;
    #1;
    check("byte_out_sel7", 64'(byte_out), 64'h03);
    sel = 3'd0;

    send_byte(8'h77, 1'b1, 1'b0);
    wait_drain(200);
    check("ovr_block", block_out, blk_exp);
    check("ovr_valid", 64'(block_valid), 64'd1);

    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    m_cnt   = 0;
    m_valid = 0;
    check("hs_cnt", 64'(byte_cnt), 64'd0);
    check("hs_valid", 64'(block_valid), 64'd0);

    send_byte(8'h5A, 1'b0, 1'b0);
    wait_drain(200);
    check("ferr_cnt", 64'(byte_cnt), 64'd0);
    send_byte(8'h11, 1'b1, 1'b0);
    wait_drain(200);
    check("after_ferr_cnt", 64'(byte_cnt), 64'd1);
    check("after_ferr_slot0", 64'(block_out[63:56]), 64'h11);

    send_byte(8'h03, 1'b1, 1'b1);
    wait_drain(200);
    check("perr_cnt", 64'(byte_cnt), 64'd1);

    send_byte(8'h21, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    wait_drain(200);
    check("to_pre_cnt", 64'(byte_cnt), 64'd3);
    push(EV_TO, 0);
    m_cnt = 0;
    wait_drain(100);
    check("to_cnt", 64'(byte_cnt), 64'd0);
    check("to_keep_slot1", 64'(block_out[55:48]), 64'h21);

    send_byte(8'h31, 1'b1, 1'b0);
    send_byte(8'h32, 1'b1, 1'b0);
    wait_drain(200);
    rx = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_cnt", 64'(byte_cnt), 64'd0);
    check("mid_rst_valid", 64'(block_valid), 64'd0);
    check("mid_rst_block", block_out, 64'd0);
    check("mid_rst_pulses", 64'({frame_err, parity_err, overrun, timeout}), 64'd0);
    m_cnt   = 0;
    m_valid = 0;
    rx      = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
    send_byte(8'h42, 1'b1, 1'b0);
    wait_drain(200);
    check("post_rst_cnt", 64'(byte_cnt), 64'd1);
    check("post_rst_slot0", 64'(block_out[63:56]), 64'h42);

    repeat (4) tick();
    check("sb_left", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_block_rx.md
UART_BLOCK_RX -- requirements
Module: uart_block_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 44, meaning clk cycles per serial bit, minimum 4.
REQ-002 Parameter NBYTES, default 16, meaning bytes per assembled block, range 2..32.
REQ-003 Parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter TIMEOUT_BITS, default 64, meaning idle bit-times before a partial block is discarded; 0 disables the timeout.
REQ-005 Ports SHALL be, in this order:
- clk  in  1  system clock; every flop is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- sel  in  $clog2(NBYTES)  byte index for byte_out.
- byte_out  out  8  stored byte at index sel.
- block_out  out  8*NBYTES  assembled block.
- block_valid  out  1  block complete, held until accepted.
- block_ready  in  1  consumer accepts the block.
- byte_cnt  out  $clog2(NBYTES+1)  bytes stored in the current block.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- parity_err  out  1  one-cycle pulse on a parity mismatch.
- overrun  out  1  one-cycle pulse when a byte is dropped.
- timeout  out  1  one-cycle pulse when a partial block is discarded.

Function
REQ-006 rx SHALL pass through a 2-flop synchroniser before any use; this adds 2 cycles of latency.
REQ-007 The bit FSM SHALL have states IDLE, START, DATA, PAR, STOP, with a bit-time counter of $clog2(CLKS_PER_BIT) bits.
REQ-008 IDLE->START on a synchronised high-to-low transition of rx.
REQ-009 In START, rx SHALL be resampled after CLKS_PER_BIT/2 cycles (integer division).
- Low: go to DATA.
- High: false start, return to IDLE, no flag raised.
REQ-010 DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample.
REQ-011 After DATA, the FSM SHALL go to PAR if PARITY!=0, otherwise to STOP.
REQ-012 PAR SHALL take one sample and compare it with odd or even parity over the 8 data bits.
REQ-013 STOP SHALL take one sample.
- Low: pulse frame_err, drop the byte, wait in IDLE until rx is high.
- High with parity mismatch: pulse parity_err, drop the byte.
- High, parity good: the byte is accepted.
REQ-014 An accepted byte SHALL be written to slot byte_cnt, and byte_cnt SHALL increment on the next cycle.
REQ-015 Slot 0 (the first byte received) SHALL occupy block_out[8*NBYTES-1 -: 8]; slot k SHALL occupy block_out[8*(NBYTES-k)-1 -: 8].
REQ-016 When byte_cnt reaches NBYTES, block_valid SHALL rise on that cycle and hold until a cycle with block_valid && block_ready.
- On that handshake cycle, byte_cnt SHALL clear to 0 and block_valid SHALL fall on the next cycle.
REQ-017 While block_valid is high, block_out SHALL be stable, and any newly accepted byte SHALL be dropped with an overrun pulse.
REQ-018 If a byte is accepted in the same cycle as the handshake, it SHALL be stored in slot 0 of the new block, byte_cnt becomes 1, and no overrun is raised.
REQ-019 byte_out SHALL be combinational from sel and the storage.
- sel >= NBYTES SHALL drive 8'h00.
REQ-020 The timeout SHALL fire when TIMEOUT_BITS!=0, 0<byte_cnt<NBYTES, and the FSM has stayed in IDLE for TIMEOUT_BITS*CLKS_PER_BIT cycles.
- Effect: pulse timeout, clear byte_cnt to 0; storage contents are not cleared.
- The timeout counter SHALL reset on every START entry.
REQ-021 Error pulses SHALL NOT change byte_cnt or block_valid.

Reset
REQ-022 While rst is low, asynchronously:
- FSM=IDLE, synchroniser flops=1, byte_cnt=0, storage=0.
- block_valid=0, all pulse outputs=0.
REQ-023 Reset in mid-frame or mid-block SHALL abandon the frame and the block; after release, the next start bit is received into slot 0.
REQ-024 Reset release SHALL be synchronised internally with a 2-flop deassertion synchroniser.

Structure
REQ-025 Package uart_pkg SHALL hold:
- the parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
- the bit-FSM state encoding.
REQ-026 Bit-level reception SHALL live in one sub-module, uart_rx_byte.
- Outputs: data[7:0], a one-cycle strobe valid, frame_err, parity_err.
- uart_block_rx instantiates it and adds slot storage, counting, handshake and timeout.

Verification
REQ-027 All scenarios SHALL use CLKS_PER_BIT=4 and NBYTES=8.
REQ-028 Block: send 02,01,0F,AA,55,3C,C3,03 with block_ready=0 -> block_valid=1, block_out=64'h02010FAA553CC303, byte_out=8'hAA at sel=3.
REQ-029 Glitch: rx low for 1 cycle -> no state change past START, byte_cnt unchanged, no error pulses.
REQ-030 Framing: send 0x5A with stop bit 0 -> one frame_err pulse, byte_cnt unchanged; a following good 0x11 lands in the current slot.
REQ-031 Overrun and handshake:
- With block_valid=1, send 0x77 -> one overrun pulse, block_out unchanged.
- Pulse block_ready for one cycle -> byte_cnt=0, block_valid=0 on the next cycle.
REQ-032 Even parity: PARITY=2, send 0x03 with parity bit 1 -> one parity_err pulse, byte dropped.
REQ-033 Timeout and reset:
- With TIMEOUT_BITS=8, send 3 bytes then idle for 32 cycles -> one timeout pulse, byte_cnt=0.
- Assert rst during DATA -> all outputs are at reset values within the same cycle.
